lift_ctrl: RTL and testbench
============================

LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, meaning row length in samples; even, >= 4.
REQ-002 SHALL have parameter AW, default 4, meaning address width; 2**AW >= N.
REQ-003 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port start_i  in  1  one-cycle request to process one row.
REQ-006 SHALL have port inv_i  in  1  0 = forward, 1 = inverse transform; sampled with start_i.
REQ-007 SHALL have port rd_addr_o  out  AW  row RAM read address.
REQ-008 SHALL have port rd_data_i  in  16  row RAM read data, valid one cycle after rd_addr_o.
REQ-009 SHALL have port wr_addr_o  out  AW  row RAM write address.
REQ-010 SHALL have port wr_data_o  out  16  row RAM write data.
REQ-011 SHALL have port wr_en_o  out  1  row RAM write strobe.
REQ-012 SHALL have ports left_o, sam_o, right_o  out  15 each  operands to lift_step.
REQ-013 SHALL have port flgs_o  out  4  lift_step operation flags.
REQ-014 SHALL have port step_upd_o  out  1  one-cycle launch pulse to lift_step.
REQ-015 SHALL have ports step_res_i  in  16 and step_done_i  in  1  lift_step result and completion pulse.
REQ-016 SHALL have ports busy_o  out  1 and done_o  out  1  row in progress; one-cycle row-complete pulse.

Function
REQ-017 SHALL run two passes per row: forward = predict on odd k (1,3,..N-1), then update on even k (0,2,..N-2); inverse = update on even k, then predict on odd k.
REQ-018 SHALL drive flgs_o from the package constants: FLG_FWD_PRED=7, FLG_FWD_UPD=5, FLG_INV_PRED=6, FLG_INV_UPD=4.
REQ-019 SHALL use left = x[k-1] and right = x[k+1] with symmetric extension: k=0 -> left = x[1]; k=N-1 -> right = x[N-2].
REQ-020 SHALL implement the FSM IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> ISSUE -> WAIT -> WB -> (RD0 | next pass RD0 | DONE) -> IDLE.
REQ-021 SHALL in RD0/RD1/RD2 present the left, sam and right addresses, and SHALL in RD1/RD2/RD3 capture rd_data_i[14:0] into left_o/sam_o/right_o.
REQ-022 SHALL in ISSUE assert step_upd_o for exactly one cycle with the operands and flgs_o stable, and SHALL hold them stable until WB.
REQ-023 SHALL remain in WAIT until step_done_i = 1, including when it arrives the cycle after ISSUE.
REQ-024 SHALL ignore step_done_i outside WAIT.
REQ-025 SHALL in WB assert wr_en_o for one cycle with wr_addr_o = k and wr_data_o = step_res_i registered at done.
REQ-026 SHALL give a per-sample cost of 6 + L cycles, where L = cycles from step_upd_o to step_done_i.
REQ-027 SHALL assert done_o in the single DONE cycle; busy_o is 1 in every state except IDLE.
REQ-028 SHALL ignore start_i while busy_o = 1, and SHALL latch inv_i only when accepting start_i.
REQ-029 SHALL wrap the sample index within 0..N-1 and SHALL never issue an address >= N.

Reset
REQ-030 SHALL on rst force state IDLE and drive all outputs to 0 (busy_o, done_o, wr_en_o, step_upd_o, addresses, operands, flgs_o).
REQ-031 SHALL on rst mid-row abandon the row with no further write; a start_i in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-032 SHALL take the FLG_* constants and the FSM state enumeration from a shared package, lift_pkg.
REQ-033 SHALL be a single module with no sub-module; the address/boundary computation is in-line.

Verification
REQ-034 Bench: N=8, x[k]=k, forward, stub step returns sam+1 with L=2; SHALL see 4 predict writes to addresses 1,3,5,7 with flgs 7, then 4 update writes to 0,2,4,6 with flgs 5; done_o at cycle 64 after start.
REQ-035 Bench: boundary, forward, x[k]=10*k; SHALL see k=7 launched with left=60, right=60, and k=0 (update pass) with left=right=x[1] as written in pass 1.
REQ-036 Bench: inverse; SHALL see the update pass (flgs 4, even addresses) before the predict pass (flgs 6, odd addresses).
REQ-037 Bench: step_done_i at L=1 and at L=9, plus spurious done pulses in RD states; SHALL see writes only in WB and per-sample cost of 7 and 15 cycles respectively.
REQ-038 Bench: start_i pulsed mid-row, then rst asserted during WAIT of k=3; SHALL see the start ignored, wr_en_o=0 and all outputs 0 the cycle after rst, and a new start accepted right after.

Source files
------------

// File: rtl/lift_pkg.sv
// lift_pkg: shared FSM states and lift_step flag encodings for lift_ctrl.
package lift_pkg;
  typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, ISSUE, WAIT, WB, DONE} state_t;
  localparam logic [3:0] FLG_FWD_PRED = 4'd7;
  localparam logic [3:0] FLG_FWD_UPD = 4'd5;
  localparam logic [3:0] FLG_INV_PRED = 4'd6;
  localparam logic [3:0] FLG_INV_UPD = 4'd4;
  function automatic logic [3:0] lift_flags(input logic inv, input logic pred);
    return pred ? (inv ? FLG_INV_PRED : FLG_FWD_PRED) : (inv ? FLG_INV_UPD : FLG_FWD_UPD);
  endfunction
endpackage

// File: rtl/lift_ctrl.sv
// lift_ctrl: sequences one row of lifting steps (predict odd / update even) through an external lift_step unit.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int N = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          inv_i,
  output logic [AW-1:0] rd_addr_o,
  input  logic [15:0]   rd_data_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [15:0]   wr_data_o,
  output logic          wr_en_o,
  output logic [14:0]   left_o,
  output logic [14:0]   sam_o,
  output logic [14:0]   right_o,
  output logic [3:0]    flgs_o,
  output logic          step_upd_o,
  input  logic [15:0]   step_res_i,
  input  logic          step_done_i,
  output logic          busy_o,
  output logic          done_o
);
  localparam logic [AW-1:0] K_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_PEN = AW'(N - 2);
  state_t state, nxt;
  logic [AW-1:0] k, a_left, a_right;
  logic pass, inv_q, pred, last, unused_msb;
  logic [15:0] res_q;
  assign unused_msb = rd_data_i[15];
  // pass 0 predicts for forward, updates for inverse
  assign pred = pass == inv_q;
  assign last = k >= K_PEN;
  // symmetric extension at both row ends
  assign a_left = k == '0 ? AW'(1) : k - AW'(1);
  assign a_right = k == K_LAST ? K_PEN : k + AW'(1);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start_i ? RD0 : IDLE;
      RD0: nxt = RD1;
      RD1: nxt = RD2;
      RD2: nxt = RD3;
      RD3: nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT: nxt = step_done_i ? WB : WAIT;
      WB: nxt = last && pass ? DONE : RD0;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      pass <= 1'b0;
      inv_q <= 1'b0;
      left_o <= '0;
      sam_o <= '0;
      right_o <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          inv_q <= inv_i;
          pass <= 1'b0;
          k <= inv_i ? '0 : AW'(1);
        end
        RD1: left_o <= rd_data_i[14:0];
        RD2: sam_o <= rd_data_i[14:0];
        RD3: right_o <= rd_data_i[14:0];
        WAIT: if (step_done_i) res_q <= step_res_i;
        WB: if (!last) k <= k + AW'(2);
          else if (!pass) begin
            pass <= 1'b1;
            k <= inv_q ? AW'(1) : '0;
          end
        default: ;
      endcase
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign step_upd_o = state == ISSUE;
  assign wr_en_o = state == WB;
  assign wr_addr_o = wr_en_o ? k : '0;
  assign wr_data_o = res_q;
  assign flgs_o = busy_o ? lift_flags(inv_q, pred) : '0;
  assign rd_addr_o = state == RD0 ? a_left : state == RD1 ? k : state == RD2 ? a_right : '0;
endmodule

// File: tb/tb_lift_ctrl.sv
// tb_lift_ctrl: randomized rows against a per-row reference model, with a write-event scoreboard.
module tb_lift_ctrl;
  localparam int N = 8;
  localparam int AW = 3;
  logic clk = 0, rst = 1, start_i = 0, inv_i = 0;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [15:0] rd_data_i = '0, wr_data_o, step_res_i = '0;
  logic wr_en_o, step_upd_o, step_done_i = 0, busy_o, done_o;
  logic [14:0] left_o, sam_o, right_o;
  logic [3:0] flgs_o;
  int checks = 0, errors = 0;

  lift_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .inv_i(inv_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
    .left_o(left_o), .sam_o(sam_o), .right_o(right_o), .flgs_o(flgs_o),
    .step_upd_o(step_upd_o), .step_res_i(step_res_i), .step_done_i(step_done_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0] d;
    logic [3:0] f;
    logic [14:0] l, s, r;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {busy_o, done_o, wr_en_o, step_upd_o, rd_addr_o, wr_addr_o, wr_data_o,
            left_o, sam_o, right_o, flgs_o};
  endfunction

  // row RAM: synchronous read, one cycle latency
  logic [15:0] mem [N];
  always @(posedge clk) begin
    if (wr_en_o) mem[wr_addr_o] = wr_data_o;
    rd_data_i <= mem[rd_addr_o];
  end

  // lift_step stub: returns sam+1 exactly lat cycles after launch, optional stray done pulses
  int lat = 2, cnt = 0;
  bit spur = 0;
  logic [15:0] hold;
  always @(negedge clk) begin
    step_res_i = 16'($urandom);
    if (rst) begin
      cnt = 0;
      step_done_i = 0;
    end else if (step_upd_o) begin
      cnt = lat;
      hold = {1'b0, sam_o} + 16'd1;
      step_done_i = 0;
    end else if (cnt > 0) begin
      cnt--;
      step_done_i = cnt == 0;
      if (cnt == 0) step_res_i = hold;
    end else step_done_i = spur && $urandom_range(0, 2) == 0;
  end

  // monitor: every write is matched against the next expected write event
  int cyc = 0, launches = 0, last_wr = 0, gap = 0;
  bit have_prev = 0;
  logic [14:0] ll, ls, lr;
  logic [3:0] lf;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (step_upd_o) begin
        ll = left_o; ls = sam_o; lr = right_o; lf = flgs_o;
        launches++;
      end
      if (wr_en_o) begin
        if (q.size() == 0) chk("unexpected_write", {wr_addr_o, wr_data_o}, '1);
        else begin
          e = q.pop_front();
          chk("wr_addr_data", {wr_addr_o, wr_data_o}, {e.a, e.d});
          chk("launch_ops", {lf, ll, ls, lr}, {e.f, e.l, e.s, e.r});
          chk("held_ops", {flgs_o, left_o, sam_o, right_o}, {e.f, e.l, e.s, e.r});
          if (have_prev) chk("sample_cost", cyc - last_wr, gap);
          have_prev = 1;
          last_wr = cyc;
        end
      end
    end
  end

  task automatic load(input int mode);
    for (int i = 0; i < N; i++)
      mem[i] = mode == 0 ? 16'(i) : mode == 1 ? 16'(10 * i) : 16'($urandom_range(0, 20000));
  endtask

  // reference: in-place lifting on a copy of the row, one pass then the other
  task automatic build(input bit inv);
    logic [15:0] x [N];
    exp_t t;
    for (int i = 0; i < N; i++) x[i] = mem[i];
    for (int ph = 0; ph < 2; ph++) begin
      bit pr;
      pr = (ph == 0) ^ inv;
      for (int k = pr ? 1 : 0; k < N; k += 2) begin
        t.a = AW'(k);
        t.l = x[k == 0 ? 1 : k - 1][14:0];
        t.s = x[k][14:0];
        t.r = x[k == N - 1 ? N - 2 : k + 1][14:0];
        t.f = pr ? (inv ? 4'd6 : 4'd7) : (inv ? 4'd4 : 4'd5);
        t.d = {1'b0, t.s} + 16'd1;
        x[k] = t.d;
        q.push_back(t);
      end
    end
  endtask

  task automatic run_row(input bit inv, input int l, input bit sp, input bit poke);
    int n;
    build(inv);
    lat = l; spur = sp; gap = 6 + l; have_prev = 0;
    start_i = 1; inv_i = inv;
    @(negedge clk);
    start_i = 0; inv_i = 1'($urandom);
    chk("busy_after_start", busy_o, 1);
    n = 0;
    while (!done_o && n < 2000) begin
      @(negedge clk);
      n++;
      start_i = poke && n == 20;
      inv_i = ~inv;
    end
    start_i = 0;
    chk("done_cycle", n, N * (6 + l));
    @(negedge clk);
    chk("idle_after_done", {busy_o, done_o}, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic reset_test();
    int n, l0;
    load(2);
    build(0);
    while (q.size() > 1) q.delete(q.size() - 1);
    lat = 9; spur = 0; gap = 15; have_prev = 0;
    l0 = launches;
    start_i = 1; inv_i = 0;
    @(negedge clk);
    start_i = 0;
    n = 0;
    while (launches < l0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
      start_i = n == 3;
      inv_i = 1;
    end
    start_i = 0;
    chk("k3_launched", launches - l0, 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("outputs_after_rst", outs(), 0);
    chk("k1_written_only", q.size(), 0);
    rst = 0;
    run_row(0, 2, 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 0;
    @(negedge clk);
    load(0); run_row(0, 2, 0, 0);
    load(1); run_row(0, 3, 0, 0);
    load(2); run_row(1, 2, 0, 0);
    load(2); run_row(0, 1, 1, 0);
    load(2); run_row(1, 9, 1, 1);
    reset_test();
    repeat (6) begin
      load(2);
      run_row(1'($urandom_range(0, 1)), $urandom_range(1, 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
